// File: rtl/cmd_parse_rw_if.sv
// Bundle of the byte-stream, register-port and response-stream signals
// around cmd_parse_rw. The parser sits on the slave side.
interface cmd_parse_rw_if #(
   parameter int AW   = 8,
   parameter int DW   = 24,
   parameter int ERRW = 8
);
   logic [7:0]      i_data;
   logic            i_valid;
   logic            o_ready;
   logic            i_last;
   logic [AW-1:0]   o_wr_addr;
   logic [DW-1:0]   o_wr_data;
   logic            o_wr_valid;
   logic [AW-1:0]   o_rd_addr;
   logic            o_rd_req;
   logic [DW-1:0]   i_rd_data;
   logic            i_rd_valid;
   logic [7:0]      o_tx_data;
   logic            o_tx_valid;
   logic            i_tx_ready;
   logic            o_tx_last;
   logic [ERRW-1:0] o_err_count;

   modport master (
      output i_data, i_valid, i_last,
      output i_rd_data, i_rd_valid, i_tx_ready,
      input  o_ready, o_wr_addr, o_wr_data, o_wr_valid,
      input  o_rd_addr, o_rd_req,
      input  o_tx_data, o_tx_valid, o_tx_last, o_err_count
   );

   modport slave (
      input  i_data, i_valid, i_last,
      input  i_rd_data, i_rd_valid, i_tx_ready,
      output o_ready, o_wr_addr, o_wr_data, o_wr_valid,
      output o_rd_addr, o_rd_req,
      output o_tx_data, o_tx_valid, o_tx_last, o_err_count
   );
endinterface

// File: rtl/cmd_parse_rw.sv
// Opcode-tagged byte-stream command parser: writes go to the register
// write port, reads are requested and answered on the response stream.
module cmd_parse_rw #(
   parameter int AW      = 8,
   parameter int DW      = 24,
   parameter int TIMEOUT = 255,
   parameter int ERRW    = 8
) (
   input logic           clk,
   input logic           rst,
   cmd_parse_rw_if.slave bus
);
   localparam int AB = AW / 8;
   localparam int DB = DW / 8;
   localparam int PW = AW + DW;
   // wide enough that the saturated value never equals a legal length
   localparam int CW = $clog2(AB + DB + 1) + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int LW = $clog2(DB + 1);

   typedef enum logic [1:0] {
      S_RX,
      S_WR,
      S_RDW,
      S_TX
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [7:0]    op;
   logic [PW-9:0] pay;
   logic [PW-1:0] pay_nxt;
   logic [TW-1:0] timer;
   logic [DW-1:0] txbuf;
   logic [LW-1:0] left;
   logic          acc;
   logic          fin;
   logic          ok_wr;
   logic          ok_rd;
   logic          hs;
   logic          ld_wr;
   logic          ld_rd;
   logic          bad;
   logic          tmo;
   logic          rd_hit;

   // o_ready is forced low while reset is held so every output reads 0
   assign bus.o_ready = (state == S_RX) && !rst;

   assign acc     = bus.i_valid && (state == S_RX);
   assign fin     = acc && bus.i_last;
   assign pay_nxt = {pay, bus.i_data};
   assign ok_wr   = (op == 8'h01) && (cnt == CW'(AB + DB));
   assign ok_rd   = (op == 8'h02) && (cnt == CW'(AB));
   assign hs      = bus.o_tx_valid && bus.i_tx_ready;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_RX;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state and per-cycle decode strobes
   always_comb begin
      state_nxt = state;
      ld_wr     = 1'b0;
      ld_rd     = 1'b0;
      bad       = 1'b0;
      tmo       = 1'b0;
      rd_hit    = 1'b0;
      unique case (state)
         S_RX: begin
            if (fin) begin
               if (ok_wr) begin
                  state_nxt = S_WR;
                  ld_wr     = 1'b1;
               end else if (ok_rd) begin
                  state_nxt = S_RDW;
                  ld_rd     = 1'b1;
               end else begin
                  bad = 1'b1;
               end
            end
         end
         S_WR: begin
            state_nxt = S_RX;
         end
         S_RDW: begin
            if (bus.i_rd_valid) begin
               rd_hit    = 1'b1;
               state_nxt = S_TX;
            end else if (timer == TW'(TIMEOUT - 1)) begin
               tmo       = 1'b1;
               state_nxt = S_TX;
            end
         end
         S_TX: begin
            if (hs && bus.o_tx_last) begin
               state_nxt = S_RX;
            end
         end
         default: begin
            state_nxt = S_RX;
         end
      endcase
   end

   // frame byte counter (saturating), opcode and payload shift register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         op  <= '0;
         pay <= '0;
      end else if (acc) begin
         if (bus.i_last) begin
            cnt <= '0;
         end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
         end
         if (cnt == '0) begin
            op <= bus.i_data;
         end else begin
            pay <= pay_nxt[PW-9:0];
         end
      end
   end

   // register write port: single-cycle strobe, address/data held
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.o_wr_valid <= 1'b0;
         bus.o_wr_addr  <= '0;
         bus.o_wr_data  <= '0;
      end else begin
         bus.o_wr_valid <= ld_wr;
         if (ld_wr) begin
            bus.o_wr_addr <= pay_nxt[PW-1 -: AW];
            bus.o_wr_data <= pay_nxt[DW-1:0];
         end
      end
   end

   // read request held until data arrives or the wait times out
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.o_rd_req  <= 1'b0;
         bus.o_rd_addr <= '0;
         timer         <= '0;
      end else begin
         if (ld_rd) begin
            bus.o_rd_req  <= 1'b1;
            bus.o_rd_addr <= pay_nxt[AW-1:0];
            timer         <= '0;
         end else if (rd_hit || tmo) begin
            bus.o_rd_req <= 1'b0;
         end else if (state == S_RDW) begin
            timer <= timer + 1'b1;
         end
      end
   end

   // response stream: DB data bytes MSB first, or a single 0xEE on timeout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.o_tx_valid <= 1'b0;
         bus.o_tx_data  <= '0;
         bus.o_tx_last  <= 1'b0;
         txbuf          <= '0;
         left           <= '0;
      end else if (rd_hit) begin
         bus.o_tx_valid <= 1'b1;
         bus.o_tx_data  <= bus.i_rd_data[DW-1 -: 8];
         bus.o_tx_last  <= (DB == 1);
         txbuf          <= bus.i_rd_data << 8;
         left           <= LW'(DB - 1);
      end else if (tmo) begin
         bus.o_tx_valid <= 1'b1;
         bus.o_tx_data  <= 8'hEE;
         bus.o_tx_last  <= 1'b1;
         left           <= '0;
      end else if (hs) begin
         if (bus.o_tx_last) begin
            bus.o_tx_valid <= 1'b0;
            bus.o_tx_last  <= 1'b0;
         end else begin
            bus.o_tx_data <= txbuf[DW-1 -: 8];
            bus.o_tx_last <= (left == LW'(1));
            txbuf         <= txbuf << 8;
            left          <= left - 1'b1;
         end
      end
   end

   // saturating count of rejected frames and read timeouts
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.o_err_count <= '0;
      end else if ((bad || tmo) && (bus.o_err_count != '1)) begin
         bus.o_err_count <= bus.o_err_count + 1'b1;
      end
   end
endmodule
